// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider slice.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int unsigned W_DEF = 32;

  // Iteration counter width; it must be able to hold W-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/cla.sv
// Parallel-prefix carry-lookahead adder: o_s = i_a + i_b + i_cin, o_cout is the carry out of the MSB.
module cla #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  logic [W-1:0] p0;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W-1:0] carries;

  // After the prefix tree, g[i]/p[i] are the group generate/propagate of bits i..0.
  always_comb begin
    p0 = i_a ^ i_b;
    g  = i_a & i_b;
    p  = p0;
    gn = '0;
    pn = '0;
    for (int unsigned lvl = 0; (32'd1 << lvl) < W; lvl++) begin
      gn = g;
      pn = p;
      for (int unsigned i = (32'd1 << lvl); i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (32'd1 << lvl)]);
        pn[i] = p[i] & p[i - (32'd1 << lvl)];
      end
      g = gn;
      p = pn;
    end
  end

  assign carries = g | (p & {W{i_cin}});
  assign o_cout  = carries[W-1];
  assign o_s     = p0 ^ {carries[W-2:0], i_cin};

endmodule

// File: rtl/seq_div.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per request, valid/ready on both sides.
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_signed,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r
);

  localparam int unsigned CW = cnt_width(W);

  div_state_e    state;
  div_state_e    state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  p_q;
  logic          neg_q_f;
  logic          neg_r_f;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  shifted;
  logic [W:0]    t_sum;
  logic          no_borrow;
  logic          unused_sum_msb;

  assign a_mag = (i_signed && i_a[W-1]) ? -i_a : i_a;
  assign b_mag = (i_signed && i_b[W-1]) ? -i_b : i_b;

  // P never reaches bit W-1 before a shift, so dropping P[W-1] here is lossless.
  assign shifted = {p_q[W-2:0], a_q[W-1]};

  cla #(.W(W + 1)) u_sub (
    .i_a    ({1'b0, shifted}),
    .i_b    (~{1'b0, b_q}),
    .i_cin  (1'b1),
    .o_s    (t_sum),
    .o_cout (no_borrow)
  );

  // The sum MSB is just the borrow flag again; carry-out already covers it.
  assign unused_sum_msb = t_sum[W];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    o_rdy    = 1'b0;
    o_vld    = 1'b0;
    case (state)
      IDLE: begin
        o_rdy = 1'b1;
        if (i_vld) begin
          state_nx = (i_b == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = DONE;
      end
      DONE: begin
        o_vld = 1'b1;
        if (i_rdy) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      neg_q_f <= 1'b0;
      neg_r_f <= 1'b0;
      o_q     <= '0;
      o_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_vld) begin
            neg_q_f <= i_signed & (i_a[W-1] ^ i_b[W-1]);
            neg_r_f <= i_signed & i_a[W-1];
            if (i_b == '0) begin
              o_q <= '1;
              o_r <= i_a;
            end else begin
              a_q <= a_mag;
              b_q <= b_mag;
              p_q <= '0;
              cnt <= CW'(W - 1);
            end
          end
        end
        BUSY: begin
          a_q <= {a_q[W-2:0], no_borrow};
          p_q <= no_borrow ? t_sum[W-1:0] : shifted;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          o_q <= neg_q_f ? -a_q : a_q;
          o_r <= neg_r_f ? -p_q : p_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (W=8): directed corner cases plus random operands against an arithmetic model.
module tb_seq_div;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         i_vld;
  logic         o_rdy;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_signed;
  logic         o_vld;
  logic         i_rdy;
  logic [W-1:0] o_q;
  logic [W-1:0] o_r;

  int n_asrt = 0;
  int n_fail = 0;

  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  seq_div #(.W(W)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .i_vld    (i_vld),
    .o_rdy    (o_rdy),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_signed (i_signed),
    .o_vld    (o_vld),
    .i_rdy    (i_rdy),
    .o_q      (o_q),
    .o_r      (o_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating division; remainder follows the dividend; x/0 gives all-ones and the dividend.
  function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b, input logic s);
    int q;
    int r;
    if (b == 8'h00) return {8'hFF, a};
    if (s) begin
      q = int'($signed(a)) / int'($signed(b));
      r = int'($signed(a)) % int'($signed(b));
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
    end
    return {q[7:0], r[7:0]};
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [15:0] exp;
    int          edges;
    bit          stable;
    exp = ref_div(a, b, s);
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(o_rdy), 32'd1);
    i_a      = a;
    i_b      = b;
    i_signed = s;
    i_vld    = 1'b1;
    @(posedge clk);
    #1;
    i_vld    = 1'b0;
    i_a      = 8'($urandom);
    i_b      = 8'($urandom);
    i_signed = 1'($urandom);
    edges    = 1;
    stable   = 1'b1;
    while (o_vld !== 1'b1 && edges < 40) begin
      if (o_q !== last_q || o_r !== last_r) stable = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, ".lat"}, 32'(edges), (b == 8'h00) ? 32'd1 : 32'(W + 2));
    chk({tag, ".vld"}, 32'(o_vld), 32'd1);
    chk({tag, ".q"}, 32'(o_q), 32'(exp[15:8]));
    chk({tag, ".r"}, 32'(o_r), 32'(exp[7:0]));
    if (b != 8'h00) chk({tag, ".hold"}, 32'(stable), 32'd1);
    last_q = exp[15:8];
    last_r = exp[7:0];
    if (i_rdy) begin
      @(posedge clk);
      #1;
      chk({tag, ".vld_drop"}, 32'(o_vld), 32'd0);
      chk({tag, ".rdy_back"}, 32'(o_rdy), 32'd1);
    end
  endtask

  initial begin
    arst_n   = 1'b0;
    i_vld    = 1'b0;
    i_rdy    = 1'b1;
    i_a      = '0;
    i_b      = '0;
    i_signed = 1'b0;
    last_q   = '0;
    last_r   = '0;
    #12;
    chk("reset.rdy", 32'(o_rdy), 32'd1);
    chk("reset.vld", 32'(o_vld), 32'd0);
    chk("reset.q", 32'(o_q), 32'd0);
    chk("reset.r", 32'(o_r), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    run_op(8'd200, 8'd7, 1'b0, "u200_7");
    chk("u200_7.q_const", 32'(o_q), 32'h1C);
    chk("u200_7.r_const", 32'(o_r), 32'h04);
    run_op(8'hF9, 8'h02, 1'b1, "s_m7_2");
    run_op(8'h07, 8'hFE, 1'b1, "s_7_m2");
    run_op(8'h55, 8'h00, 1'b0, "u_div0");
    run_op(8'h55, 8'h00, 1'b1, "s_div0");
    run_op(8'h80, 8'hFF, 1'b1, "s_min_m1");
    run_op(8'h80, 8'hFF, 1'b0, "u_80_ff");
    run_op(8'hFE, 8'hFF, 1'b0, "u_fe_ff");
    run_op(8'h80, 8'h01, 1'b1, "s_min_1");

    // Backpressure: result must hold while new requests are ignored.
    i_rdy = 1'b0;
    run_op(8'd195, 8'd10, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_vld", 32'(o_vld), 32'd1);
      chk("bp.hold_q", 32'(o_q), 32'd19);
      chk("bp.hold_r", 32'(o_r), 32'd5);
      chk("bp.hold_rdy", 32'(o_rdy), 32'd0);
      i_vld    = 1'b1;
      i_a      = 8'($urandom);
      i_b      = 8'($urandom_range(1, 255));
      i_signed = 1'($urandom);
    end
    @(negedge clk);
    i_vld = 1'b0;
    chk("bp.hold_vld_end", 32'(o_vld), 32'd1);
    chk("bp.hold_q_end", 32'(o_q), 32'd19);
    i_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_vld", 32'(o_vld), 32'd0);
    chk("bp.release_rdy", 32'(o_rdy), 32'd1);
    run_op(8'd250, 8'd3, 1'b0, "bp_next");

    // Asynchronous reset in the middle of the iterations.
    @(negedge clk);
    i_a      = 8'hAB;
    i_b      = 8'h05;
    i_signed = 1'b0;
    i_vld    = 1'b1;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk("rst_mid.vld", 32'(o_vld), 32'd0);
    chk("rst_mid.rdy", 32'(o_rdy), 32'd1);
    chk("rst_mid.q", 32'(o_q), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    last_q = '0;
    last_r = '0;
    run_op(8'd100, 8'd9, 1'b0, "post_rst");
    chk("post_rst.q_const", 32'(o_q), 32'd11);
    chk("post_rst.r_const", 32'(o_r), 32'd1);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
